// File: rtl/prog_ctr_seq.sv
// -----------------------------------------------------------------------------
// prog_ctr_seq
//   Program counter and program sequencer for the single-issue core. Programs
//   are launched one at a time, in order, from a packed entry-address table.
//   Each high pulse on Start requests the next program. The launch happens when
//   the pulse ends. While a program runs, the PC steps by one, branches
//   relative up or down, jumps to an absolute target, or holds on Stall. Halt
//   ends the program. When every table entry has been launched, the next
//   request parks the block in EXHAUSTED, and only Reset leaves that state.
//
// Ports
//   Clk        in   1      clock, all state changes on the rising edge
//   Reset      in   1      synchronous, active-high
//   Start      in   1      program request, level (launch on the falling edge)
//   Stall      in   1      hold the PC this cycle (RUN only)
//   BranchUp   in   1      PC <= PC - PCTarget
//   BranchDown in   1      PC <= PC + PCTarget
//   BranchAbs  in   1      PC <= AbsTarget
//   Halt       in   1      the current program has finished
//   PCTarget   in   OFFW   relative offset, unsigned magnitude
//   AbsTarget  in   L      absolute jump target
//   ProgCtr    out  L      PC register
//   ProgIdx    out  4      index of the current or last-launched program
//   Running    out  1      high in RUN
//   Done       out  1      high in DONE and EXHAUSTED
// -----------------------------------------------------------------------------
module prog_ctr_seq #(
    parameter int L     = 10,
    parameter int OFFW  = 8,
    parameter int NPROG = 4,
    parameter logic [NPROG*L-1:0] ENTRY_TABLE = {10'd800, 10'd639, 10'd190, 10'd0}
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Stall,
    input  logic            BranchUp,
    input  logic            BranchDown,
    input  logic            BranchAbs,
    input  logic            Halt,
    input  logic [OFFW-1:0] PCTarget,
    input  logic [L-1:0]    AbsTarget,
    output logic [L-1:0]    ProgCtr,
    output logic [3:0]      ProgIdx,
    output logic            Running,
    output logic            Done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        RUN       = 3'd2,
        DONE      = 3'd3,
        EXHAUSTED = 3'd4
    } state_t;

    state_t         state_r;
    logic           start_r;
    logic [3:0]     launch_cnt_r;
    logic [L-1:0]   prog_ctr_r;
    logic [3:0]     prog_idx_r;
    logic           running_r;
    logic           done_r;

    logic           rise_s;
    logic           fall_s;
    logic [L-1:0]   offset_s;
    logic [L-1:0]   pc_next_s;
    logic [L-1:0]   entry_s;

    // Select an entry address from the packed table. An index past the table
    // returns 0. The caller never uses that value because it only reads the
    // table while launches remain.
    function automatic logic [L-1:0] entry_at(input logic [3:0] idx);
        logic [L-1:0] val;
        val = '0;
        for (int k = 0; k < NPROG; k++) begin
            val = (idx == 4'(k)) ? ENTRY_TABLE[k*L +: L] : val;
        end
        return val;
    endfunction

    // Detect the edges of Start against its registered copy.
    always_comb begin
        rise_s = !start_r && Start;
        fall_s = start_r && !Start;
    end

    // Entry address of the next program to launch.
    always_comb begin
        entry_s = entry_at(launch_cnt_r);
    end

    // Next PC while running. Halt and pre-emption are handled in the FSM,
    // because both leave the PC untouched.
    always_comb begin
        offset_s = L'(PCTarget);
        if (BranchAbs) begin
            pc_next_s = AbsTarget;
        end else if (BranchUp) begin
            pc_next_s = prog_ctr_r - offset_s;
        end else if (BranchDown) begin
            pc_next_s = prog_ctr_r + offset_s;
        end else if (Stall) begin
            pc_next_s = prog_ctr_r;
        end else begin
            pc_next_s = prog_ctr_r + L'(1);
        end
    end

    // Sequencer FSM. It also holds the PC and the registered status outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= IDLE;
            start_r      <= 1'b0;
            launch_cnt_r <= 4'd0;
            prog_ctr_r   <= '0;
            prog_idx_r   <= 4'd0;
            running_r    <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            start_r <= Start;
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_r <= ARMED;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ARMED: begin
                    if (fall_s) begin
                        if (launch_cnt_r < 4'(NPROG)) begin
                            state_r      <= RUN;
                            prog_ctr_r   <= entry_s;
                            prog_idx_r   <= launch_cnt_r;
                            launch_cnt_r <= launch_cnt_r + 4'd1;
                            running_r    <= 1'b1;
                        end else begin
                            state_r <= EXHAUSTED;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ARMED;
                    end
                end
                RUN: begin
                    if (Halt) begin
                        state_r   <= DONE;
                        running_r <= 1'b0;
                        done_r    <= 1'b1;
                    end else if (rise_s) begin
                        // Pre-emption abandons the program. The PC is frozen
                        // at its current value while the new request is armed.
                        state_r   <= ARMED;
                        running_r <= 1'b0;
                    end else begin
                        prog_ctr_r <= pc_next_s;
                    end
                end
                DONE: begin
                    if (rise_s) begin
                        state_r <= ARMED;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                EXHAUSTED: begin
                    state_r <= EXHAUSTED;
                end
                default: begin
                    // An illegal encoding falls back to a quiet idle state.
                    state_r   <= IDLE;
                    running_r <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign ProgCtr = prog_ctr_r;
    assign ProgIdx = prog_idx_r;
    assign Running = running_r;
    assign Done    = done_r;

endmodule

// File: tb/tb_prog_ctr_seq.sv
// -----------------------------------------------------------------------------
// tb_prog_ctr_seq
//   Directed scoreboard bench for prog_ctr_seq. The stimulus process applies
//   one vector per cycle on the falling clock edge. With each vector it pushes
//   the outputs expected after the next rising edge. A monitor samples the
//   outputs 1 time unit after every rising edge, pops the expected values, and
//   compares them.
// -----------------------------------------------------------------------------
module tb_prog_ctr_seq;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Stall;
    logic       BranchUp;
    logic       BranchDown;
    logic       BranchAbs;
    logic       Halt;
    logic [7:0] PCTarget;
    logic [9:0] AbsTarget;
    logic [9:0] ProgCtr;
    logic [3:0] ProgIdx;
    logic       Running;
    logic       Done;

    typedef struct {
        logic [9:0] pc;
        logic [3:0] idx;
        logic       run;
        logic       done;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    prog_ctr_seq dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Stall     (Stall),
        .BranchUp  (BranchUp),
        .BranchDown(BranchDown),
        .BranchAbs (BranchAbs),
        .Halt      (Halt),
        .PCTarget  (PCTarget),
        .AbsTarget (AbsTarget),
        .ProgCtr   (ProgCtr),
        .ProgIdx   (ProgIdx),
        .Running   (Running),
        .Done      (Done)
    );

    // Free-running clock.
    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare outputs just after every rising edge that has a
    // pending expectation.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, ".ProgCtr"}, int'(ProgCtr), int'(e.pc));
            check({e.tag, ".ProgIdx"}, int'(ProgIdx), int'(e.idx));
            check({e.tag, ".Running"}, int'(Running), int'(e.run));
            check({e.tag, ".Done"},    int'(Done),    int'(e.done));
        end
    end

    // Apply one cycle of stimulus and queue the outputs expected after the
    // next rising edge.
    // ctl = {Reset, Start, Stall, BranchUp, BranchDown, BranchAbs, Halt}.
    task automatic cyc(input logic [6:0] ctl, input logic [7:0] tgt,
                       input logic [9:0] abst, input logic [9:0] epc,
                       input logic [3:0] eidx, input logic erun,
                       input logic edone, input string tag);
        exp_t e;
        @(negedge Clk);
        Reset      = ctl[6];
        Start      = ctl[5];
        Stall      = ctl[4];
        BranchUp   = ctl[3];
        BranchDown = ctl[2];
        BranchAbs  = ctl[1];
        Halt       = ctl[0];
        PCTarget   = tgt;
        AbsTarget  = abst;
        e.pc   = epc;
        e.idx  = eidx;
        e.run  = erun;
        e.done = edone;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Stall = 1'b0; BranchUp = 1'b0;
        BranchDown = 1'b0; BranchAbs = 1'b0; Halt = 1'b0;
        PCTarget = 8'd0; AbsTarget = 10'd0;

        // Reset, then 20 idle cycles with no Start.
        cyc(7'b1000000, 8'd0, 10'd0, 10'd0, 4'd0, 1'b0, 1'b0, "reset");
        cyc(7'b1000000, 8'd0, 10'd0, 10'd0, 4'd0, 1'b0, 1'b0, "reset");
        for (int k = 0; k < 20; k++)
            cyc(7'b0000000, 8'd0, 10'd0, 10'd0, 4'd0, 1'b0, 1'b0, "idle");

        // Program 0 from entry 0, 5 increments, then Halt beats BranchAbs.
        cyc(7'b0100000, 8'd0, 10'd0, 10'd0, 4'd0, 1'b0, 1'b0, "arm0");
        cyc(7'b0000000, 8'd0, 10'd0, 10'd0, 4'd0, 1'b1, 1'b0, "launch0");
        for (int k = 1; k <= 5; k++)
            cyc(7'b0000000, 8'd0, 10'd0, 10'(k), 4'd0, 1'b1, 1'b0, "incr");
        cyc(7'b0000011, 8'd0, 10'd300, 10'd5, 4'd0, 1'b0, 1'b1, "halt0");
        cyc(7'b0000000, 8'd0, 10'd0, 10'd5, 4'd0, 1'b0, 1'b1, "done_hold");

        // Program 1: relative and absolute branches, both wrap directions.
        cyc(7'b0100000, 8'd0, 10'd0, 10'd5, 4'd0, 1'b0, 1'b0, "arm1");
        cyc(7'b0000000, 8'd0, 10'd0, 10'd190, 4'd1, 1'b1, 1'b0, "launch1");
        cyc(7'b0000100, 8'd10, 10'd0, 10'd200, 4'd1, 1'b1, 1'b0, "bdown");
        cyc(7'b0001000, 8'd50, 10'd0, 10'd150, 4'd1, 1'b1, 1'b0, "bup");
        cyc(7'b0000010, 8'd0, 10'd1023, 10'd1023, 4'd1, 1'b1, 1'b0, "babs");
        cyc(7'b0000000, 8'd0, 10'd0, 10'd0, 4'd1, 1'b1, 1'b0, "wrap_inc");
        cyc(7'b0001100, 8'd3, 10'd0, 10'd1021, 4'd1, 1'b1, 1'b0, "updown");

        // Stall holds. A branch overrides Stall.
        for (int k = 0; k < 4; k++)
            cyc(7'b0010000, 8'd0, 10'd0, 10'd1021, 4'd1, 1'b1, 1'b0, "stall");
        cyc(7'b0010100, 8'd2, 10'd0, 10'd1023, 4'd1, 1'b1, 1'b0, "stall_br");

        // Pre-emption at PC 195. Branch, Stall and Halt are ignored while armed.
        cyc(7'b0000010, 8'd0, 10'd195, 10'd195, 4'd1, 1'b1, 1'b0, "abs195");
        cyc(7'b0100000, 8'd0, 10'd0, 10'd195, 4'd1, 1'b0, 1'b0, "preempt");
        cyc(7'b0110010, 8'd0, 10'd5, 10'd195, 4'd1, 1'b0, 1'b0, "armed_hold");
        cyc(7'b0100001, 8'd0, 10'd0, 10'd195, 4'd1, 1'b0, 1'b0, "armed_hold2");
        cyc(7'b0000000, 8'd0, 10'd0, 10'd639, 4'd2, 1'b1, 1'b0, "launch2");

        // Program 3 by pre-emption, then Halt. The fifth request exhausts.
        cyc(7'b0100000, 8'd0, 10'd0, 10'd639, 4'd2, 1'b0, 1'b0, "preempt2");
        cyc(7'b0000000, 8'd0, 10'd0, 10'd800, 4'd3, 1'b1, 1'b0, "launch3");
        cyc(7'b0000000, 8'd0, 10'd0, 10'd801, 4'd3, 1'b1, 1'b0, "inc801");
        cyc(7'b0000001, 8'd0, 10'd0, 10'd801, 4'd3, 1'b0, 1'b1, "halt3");
        cyc(7'b0100000, 8'd0, 10'd0, 10'd801, 4'd3, 1'b0, 1'b0, "arm4");
        cyc(7'b0000000, 8'd0, 10'd0, 10'd801, 4'd3, 1'b0, 1'b1, "exhaust");
        cyc(7'b0100000, 8'd0, 10'd0, 10'd801, 4'd3, 1'b0, 1'b1, "exh_ign");
        cyc(7'b0000010, 8'd0, 10'd7, 10'd801, 4'd3, 1'b0, 1'b1, "exh_ign2");

        // Reset clears the launch count. The next pulse launches entry 0.
        cyc(7'b1000000, 8'd0, 10'd0, 10'd0, 4'd0, 1'b0, 1'b0, "reset2");
        cyc(7'b0100000, 8'd0, 10'd0, 10'd0, 4'd0, 1'b0, 1'b0, "rearm");
        cyc(7'b0000000, 8'd0, 10'd0, 10'd0, 4'd0, 1'b1, 1'b0, "relaunch");
        cyc(7'b0001000, 8'd1, 10'd0, 10'd1023, 4'd0, 1'b1, 1'b0, "wrap_up");
        cyc(7'b0000000, 8'd0, 10'd0, 10'd0, 4'd0, 1'b1, 1'b0, "wrap_inc2");

        // Bounded drain of the scoreboard.
        repeat (3) @(posedge Clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
